// File: rtl/bus_regfile_pkg.sv
// bus_regfile_pkg: shared types and helpers for the bus register file.
// Holds the write-op encoding and the priority decode from the raw
// control strobes, so the top and the step datapath agree on one meaning.
package bus_regfile_pkg;

  // Largest number of entries one instance may hold.
  localparam int MAX_DEPTH = 16;

  // One write operation per clock edge, already priority-resolved.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_INC,
    OP_DEC
  } op_e;

  // Clear beats load, load beats inc/dec, and inc+dec together cancel out.
  function automatic op_e decode_op(input logic clr_sel,
                                    input logic load,
                                    input logic inc,
                                    input logic dec);
    if (clr_sel)       return OP_CLR;
    if (load)          return OP_LOAD;
    if (inc && !dec)   return OP_INC;
    if (dec && !inc)   return OP_DEC;
    return OP_HOLD;
  endfunction

endpackage

// File: rtl/bus_regfile_if.sv
// bus_regfile_if: control, select and data signals between a CPU-side bus
// master and the register file. The zero/carry flags exist only when
// BUS_REGFILE_FLAGS_EN is defined.
interface bus_regfile_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);

  logic             load;
  logic             inc;
  logic             dec;
  logic             clr_sel;
  logic [AW-1:0]    wr_sel;
  logic             enable;
  logic [AW-1:0]    rd_sel;
  logic [AW-1:0]    mon_sel;
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] data_out;
`ifdef BUS_REGFILE_FLAGS_EN
  logic             zero;
  logic             carry;
`endif

  modport master (
    output load, inc, dec, clr_sel, wr_sel, enable, rd_sel, mon_sel, bus,
    input  data_out
`ifdef BUS_REGFILE_FLAGS_EN
    , input zero, carry
`endif
  );

  modport slave (
    input  load, inc, dec, clr_sel, wr_sel, enable, rd_sel, mon_sel, bus,
    output data_out
`ifdef BUS_REGFILE_FLAGS_EN
    , output zero, carry
`endif
  );

endinterface

// File: rtl/bus_regfile_step.sv
// bus_regfile_step: next value of one entry for a decoded write op.
// Arithmetic wraps modulo 2^WIDTH; carry_o marks an inc or dec that wrapped.
module bus_regfile_step
  import bus_regfile_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] cur_i,
  input  logic [WIDTH-1:0] bus_i,
  output logic [WIDTH-1:0] nxt_o,
  output logic             carry_o
);

  // Compute the new entry value and wrap indication for the requested op.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    nxt_o   = cur_i;
    carry_o = 1'b0;
    unique case (op_i)
      OP_CLR:  nxt_o = '0;
      OP_LOAD: nxt_o = bus_i;
      OP_INC:  {carry_o, nxt_o} = {1'b0, cur_i} + (WIDTH + 1)'(1);
      OP_DEC: begin
        nxt_o   = cur_i - WIDTH'(1);
        carry_o = (cur_i == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_regfile.sv
// bus_regfile: DEPTH x WIDTH register file on the shared CPU bus.
// Addressed load / inc / dec / clear on wr_sel, tri-state read of rd_sel
// onto bus_out, and a permanent monitor of mon_sel on data_out. Selects at
// or beyond DEPTH write nothing and read as 0.
// Optional: define BUS_REGFILE_FLAGS_EN to add registered zero/carry flags.
module bus_regfile
  import bus_regfile_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clear_n,
  bus_regfile_if.slave     rf,
  output wire [WIDTH-1:0]  bus_out
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH itself is representable in the range compare.
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || DEPTH > MAX_DEPTH) begin : g_depth_check
    $error("bus_regfile: DEPTH must be within 2..16");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_hit;
  logic             rd_hit;
  logic             mon_hit;
  logic             wr_en;
  op_e              op;
  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] rd_val;
  logic [WIDTH-1:0] nxt_d;
  logic             step_carry;

  // Decode selects and the write op; read ports are pure decodes of the array.
  always_comb begin
    wr_hit  = {1'b0, rf.wr_sel}  < DEPTH_W;
    rd_hit  = {1'b0, rf.rd_sel}  < DEPTH_W;
    mon_hit = {1'b0, rf.mon_sel} < DEPTH_W;
    op      = decode_op(rf.clr_sel, rf.load, rf.inc, rf.dec);
    wr_en   = wr_hit && (op != OP_HOLD);
    cur_val     = '0;
    rd_val      = '0;
    rf.data_out = '0;
    if (wr_hit)  cur_val     = mem_q[rf.wr_sel];
    if (rd_hit)  rd_val      = mem_q[rf.rd_sel];
    if (mon_hit) rf.data_out = mem_q[rf.mon_sel];
  end

  bus_regfile_step #(.WIDTH(WIDTH)) u_step (
    .op_i    (op),
    .cur_i   (cur_val),
    .bus_i   (rf.bus),
    .nxt_o   (nxt_d),
    .carry_o (step_carry)
  );

  // Storage: clear everything on reset, else update only the addressed entry.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      // NOTE: the array is plain flops, not a RAM macro, and every entry must
      // read 0 straight out of reset, so each one is reset explicitly.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      // NOTE: non-blocking so the value read on the bus this cycle is the
      // pre-edge one, which is what makes same-entry read+load safe.
      mem_q[rf.wr_sel] <= nxt_d;
    end
  end

  // Drive the shared bus only while enabled; the stored array feeds it directly.
  assign bus_out = rf.enable ? rd_val : {WIDTH{1'bz}};

`ifdef BUS_REGFILE_FLAGS_EN
  logic zero_q;
  logic carry_q;

  // Flags follow the last write op that actually changed an in-range entry.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (wr_en) begin
      zero_q  <= (nxt_d == '0);
      carry_q <= step_carry;
    end
  end

  assign rf.zero  = zero_q;
  assign rf.carry = carry_q;
`else
  wire unused_step_carry = step_carry;
`endif

endmodule
